alu_share_arbiter: RTL

//  Shares one combinational ALU instance among NUM_REQ requesters (e.g. main datapath, branch-compare, address-gen).

---
 rtl/alu_share_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU among NUM_REQ requesters.
// Optional per-requester grant counters on perf_grants when ALU_ARB_PERF_EN is defined.
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef ALU_ARB_PERF_EN
    output logic [NUM_REQ*16-1:0] perf_grants,
`endif
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]  req_sel,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [3:0]            alu_sel,
    input  logic [31:0]           alu_out,
    input  logic                  alu_zero,
    input  logic                  alu_ovf,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic                  rsp_zero,
    output logic                  rsp_ovf
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nx;
    logic [ID_W-1:0] rr_ptr, win, lo, hi, id_q;
    logic any, hit, hs;
    logic [31:0] a_w, b_w;
    logic [3:0] sel_w;
    // Winner: lowest valid index at or above rr_ptr, else lowest valid index overall (wrap).
    always_comb begin
        lo = '0;
        hi = '0;
        any = 1'b0;
        hit = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo = ID_W'(i);
                any = 1'b1;
            end
            if (req_valid[i] && i >= int'(rr_ptr)) begin
                hi = ID_W'(i);
                hit = 1'b1;
            end
        end
        win = hit ? hi : lo;
    end
    assign hs = (state == IDLE) && any;
    always_comb begin
        req_ready = '0;
        a_w = '0;
        b_w = '0;
        sel_w = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = hs && rst_n && (win == ID_W'(i));
            if (win == ID_W'(i)) begin
                a_w = req_a[32*i +: 32];
                b_w = req_b[32*i +: 32];
                sel_w = req_sel[4*i +: 4];
            end
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = any ? EXEC : IDLE;
            EXEC:    state_nx = RESP;
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            id_q <= '0;
            alu_a <= '0;
            alu_b <= '0;
            alu_sel <= '0;
            rsp_valid <= 1'b0;
            rsp_id <= '0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_ovf <= 1'b0;
        end else begin
            state <= state_nx;
            if (hs) begin
                alu_a <= a_w;
                alu_b <= b_w;
                alu_sel <= sel_w;
                id_q <= win;
                rr_ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end
            if (state == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_id <= id_q;
                rsp_data <= alu_out;
                rsp_zero <= alu_zero;
                rsp_ovf <= alu_ovf;
            end
            if (state == RESP && rsp_ready)
                rsp_valid <= 1'b0;
        end
    end
`ifdef ALU_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_grants <= '0;
        else
            for (int i = 0; i < NUM_REQ; i++)
                if (hs && win == ID_W'(i) && perf_grants[16*i +: 16] != 16'hFFFF)
                    perf_grants[16*i +: 16] <= perf_grants[16*i +: 16] + 16'd1;
    end
`endif
endmodule
